// File: rtl/divisor_8x4bits.sv
// Sequential restoring divider: N-bit dividend / M-bit divisor -> N-bit quotient, M-bit remainder.
// Latency: N+1 cycles from en_i sampled high in IDLE to done_o (one quotient bit per clock).
// Flow control: start is level-sensitive in IDLE; result is held in END/ERR until en_i is released.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-low
//   A_i / B_i    dividend / divisor, captured only while in IDLE
//   en_i         start request (IDLE) and release handshake (END/ERR)
//   Q_o / R_o    registered quotient / remainder, held until next completion or reset
//   done_o       high in DIV_END or DIV_ERR
//   err_o        high in DIV_ERR (divide by zero)
//   fsm_state_o  current FSM state code
module divisor_8x4bits #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] A_i,
  input  logic [M-1:0] B_i,
  input  logic         en_i,
  output logic [N-1:0] Q_o,
  output logic [M-1:0] R_o,
  output logic         done_o,
  output logic         err_o,
  output logic [3:0]   fsm_state_o
);

  localparam int CW = $clog2(N + 1);

  localparam logic [3:0] DIV_IDLE = 4'd0;
  localparam logic [3:0] DIV_ITER = 4'd1;
  localparam logic [3:0] DIV_END  = 4'd2;
  localparam logic [3:0] DIV_ERR  = 4'd3;

  logic [3:0]    state;
  logic [N-1:0]  dvd;
  logic [M-1:0]  dvs;
  logic [M:0]    rem;
  logic [N-1:0]  quo;
  logic [CW-1:0] cnt;

  logic [M:0]    t;
  logic          q_bit;
  logic [M:0]    rem_nxt;
  logic [N-1:0]  quo_nxt;

  // Shift the next dividend bit into the partial remainder. rem < dvs always
  // holds between steps, so rem[M] is zero and dropping it loses nothing.
  assign t       = (M+1)'({rem, dvd[N-1]});
  assign q_bit   = (t >= {1'b0, dvs});
  assign rem_nxt = q_bit ? (t - {1'b0, dvs}) : t;
  assign quo_nxt = N'({quo, q_bit});

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= DIV_IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      Q_o   <= '0;
      R_o   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          // Operands are re-captured every idle cycle so the start edge sees current inputs.
          dvd <= A_i;
          dvs <= B_i;
          rem <= '0;
          quo <= '0;
          cnt <= CW'(N);
          if (en_i) begin
            if (B_i == '0) begin
              state <= DIV_ERR;
              Q_o   <= '1;
              R_o   <= '0;
            end else begin
              state <= DIV_ITER;
            end
          end
        end
        DIV_ITER: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          dvd <= dvd << 1;
          cnt <= cnt - CW'(1);
          // Last step: publish the values computed on this edge, not the stale registers.
          if (cnt == CW'(1)) begin
            state <= DIV_END;
            Q_o   <= quo_nxt;
            R_o   <= rem_nxt[M-1:0];
          end
        end
        DIV_END, DIV_ERR: begin
          if (!en_i) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign done_o      = (state == DIV_END) || (state == DIV_ERR);
  assign err_o       = (state == DIV_ERR);
  assign fsm_state_o = state;

endmodule

// File: tb/tb_divisor_8x4bits.sv
// Directed and exhaustive bench for divisor_8x4bits.
// Latency: checks done_o arrives N+1 edges after the start edge.
// Flow control: exercises start/release handshake, hold in END/ERR and async abort.
module tb_divisor_8x4bits;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic [3:0] b = '0;
  logic       en = 1'b0;
  logic [7:0] q;
  logic [3:0] r;
  logic       done;
  logic       err;
  logic [3:0] fsm;

  int n_cmp = 0;
  int n_bad = 0;

  divisor_8x4bits #(.N(8), .M(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .A_i         (a),
    .B_i         (b),
    .en_i        (en),
    .Q_o         (q),
    .R_o         (r),
    .done_o      (done),
    .err_o       (err),
    .fsm_state_o (fsm)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus helper: start a division, wait (bounded) for done, capture, release.
  task automatic run_div(input logic [7:0] av, input logic [3:0] bv,
                         output logic [7:0] qv, output logic [3:0] rv,
                         output int edges, output int iters,
                         output logic ev, output logic [3:0] sv);
    a = av;
    b = bv;
    en = 1'b1;
    edges = 0;
    iters = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      edges++;
      if (fsm == 4'd1) iters++;
      if (done) break;
    end
    qv = q;
    rv = r;
    ev = err;
    sv = fsm;
    en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (fsm !== 4'd0) begin n_bad++; $display("FAIL reset_state got=%0d want=0", fsm); end
    n_cmp++; if (q !== 8'd0) begin n_bad++; $display("FAIL reset_q got=%0d want=0", q); end
    n_cmp++; if (r !== 4'd0) begin n_bad++; $display("FAIL reset_r got=%0d want=0", r); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_flags got done=%b err=%b want 0/0", done, err); end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] qv; logic [3:0] rv; int edges; int iters; logic ev; logic [3:0] sv;
    run_div(8'd200, 4'd7, qv, rv, edges, iters, ev, sv);
    n_cmp++; if (edges !== 9) begin n_bad++; $display("FAIL basic_latency got=%0d want=9", edges); end
    n_cmp++; if (iters !== 8) begin n_bad++; $display("FAIL basic_iter_cycles got=%0d want=8", iters); end
    n_cmp++; if (qv !== 8'd28) begin n_bad++; $display("FAIL basic_q got=%0d want=28", qv); end
    n_cmp++; if (rv !== 4'd4) begin n_bad++; $display("FAIL basic_r got=%0d want=4", rv); end
    n_cmp++; if (ev !== 1'b0) begin n_bad++; $display("FAIL basic_err got=%b want=0", ev); end
    n_cmp++; if (sv !== 4'd2) begin n_bad++; $display("FAIL basic_state got=%0d want=2", sv); end
    n_cmp++; if (fsm !== 4'd0 || done !== 1'b0) begin n_bad++; $display("FAIL basic_release got state=%0d done=%b want 0/0", fsm, done); end
    n_cmp++; if (q !== 8'd28) begin n_bad++; $display("FAIL basic_q_hold got=%0d want=28", q); end
  endtask

  task automatic test_boundary();
    logic [7:0] av [4] = '{8'd255, 8'd255, 8'd5, 8'd0};
    logic [3:0] bv [4] = '{4'd1,   4'd15,  4'd9, 4'd3};
    logic [7:0] qe [4] = '{8'd255, 8'd17,  8'd0, 8'd0};
    logic [3:0] re [4] = '{4'd0,   4'd0,   4'd5, 4'd0};
    logic [7:0] qv; logic [3:0] rv; int edges; int iters; logic ev; logic [3:0] sv;
    for (int i = 0; i < 4; i++) begin
      run_div(av[i], bv[i], qv, rv, edges, iters, ev, sv);
      n_cmp++; if (qv !== qe[i]) begin n_bad++; $display("FAIL bound_q %0d/%0d got=%0d want=%0d", av[i], bv[i], qv, qe[i]); end
      n_cmp++; if (rv !== re[i]) begin n_bad++; $display("FAIL bound_r %0d/%0d got=%0d want=%0d", av[i], bv[i], rv, re[i]); end
    end
  endtask

  task automatic test_div_zero();
    a = 8'd100;
    b = 4'd0;
    en = 1'b1;
    step();
    n_cmp++; if (fsm !== 4'd3) begin n_bad++; $display("FAIL dz_state got=%0d want=3", fsm); end
    n_cmp++; if (err !== 1'b1 || done !== 1'b1) begin n_bad++; $display("FAIL dz_flags got err=%b done=%b want 1/1", err, done); end
    n_cmp++; if (q !== 8'd255) begin n_bad++; $display("FAIL dz_q got=%0d want=255", q); end
    n_cmp++; if (r !== 4'd0) begin n_bad++; $display("FAIL dz_r got=%0d want=0", r); end
    step();
    n_cmp++; if (fsm !== 4'd3) begin n_bad++; $display("FAIL dz_hold got=%0d want=3", fsm); end
    en = 1'b0;
    step();
    n_cmp++; if (fsm !== 4'd0 || err !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL dz_release got state=%0d err=%b done=%b want 0/0/0", fsm, err, done); end
    n_cmp++; if (q !== 8'd255) begin n_bad++; $display("FAIL dz_q_hold got=%0d want=255", q); end
  endtask

  task automatic test_ignore_changes();
    int edges;
    a = 8'd200;
    b = 4'd7;
    en = 1'b1;
    step();
    a = 8'd1;
    b = 4'd1;
    edges = 1;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      en = ~en;
      step();
      edges++;
    end
    n_cmp++; if (edges !== 9) begin n_bad++; $display("FAIL ign_latency got=%0d want=9", edges); end
    n_cmp++; if (q !== 8'd28 || r !== 4'd4) begin n_bad++; $display("FAIL ign_result got q=%0d r=%0d want 28/4", q, r); end
    en = 1'b1;
    step();
    n_cmp++; if (fsm !== 4'd2) begin n_bad++; $display("FAIL ign_hold got=%0d want=2", fsm); end
    en = 1'b0;
    step();
    n_cmp++; if (fsm !== 4'd0) begin n_bad++; $display("FAIL ign_release got=%0d want=0", fsm); end
  endtask

  task automatic test_async_reset();
    logic [7:0] qv; logic [3:0] rv; int edges; int iters; logic ev; logic [3:0] sv;
    a = 8'd200;
    b = 4'd7;
    en = 1'b1;
    step();
    repeat (4) step();
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (fsm !== 4'd0) begin n_bad++; $display("FAIL arst_state got=%0d want=0", fsm); end
    n_cmp++; if (q !== 8'd0 || r !== 4'd0) begin n_bad++; $display("FAIL arst_result got q=%0d r=%0d want 0/0", q, r); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL arst_done got=%b want=0", done); end
    #2 rst_n = 1'b1;
    step();
    run_div(8'd13, 4'd4, qv, rv, edges, iters, ev, sv);
    n_cmp++; if (qv !== 8'd3 || rv !== 4'd1) begin n_bad++; $display("FAIL arst_after got q=%0d r=%0d want 3/1", qv, rv); end
  endtask

  task automatic test_sweep();
    logic [7:0] qv; logic [3:0] rv; int edges; int iters; logic ev; logic [3:0] sv;
    logic [7:0] qe; logic [3:0] re;
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        qe = 8'(ai / bi);
        re = 4'(ai % bi);
        run_div(8'(ai), 4'(bi), qv, rv, edges, iters, ev, sv);
        n_cmp++; if (qv !== qe) begin n_bad++; $display("FAIL sweep_q %0d/%0d got=%0d want=%0d", ai, bi, qv, qe); end
        n_cmp++; if (rv !== re) begin n_bad++; $display("FAIL sweep_r %0d/%0d got=%0d want=%0d", ai, bi, rv, re); end
        n_cmp++; if (edges !== 9) begin n_bad++; $display("FAIL sweep_latency %0d/%0d got=%0d want=9", ai, bi, edges); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_ignore_changes();
    test_async_reset();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
